// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/exception addresses, NOP encoding
// and the fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] NOP_INST       = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        CANCEL = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_npc_sel.sv
// Next-fetch-address mux: except > eret > taken branch (new or pending) > fpc+4.
// Also flags a non-word-aligned result.
module if_npc_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        except,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        pending_valid,
    input  logic [31:0] pending_target,
    input  logic [31:0] fpc,
    output logic [31:0] npc,
    output logic        misaligned
);

    always_comb begin
        npc = fpc + 32'd4;
        if (except)
            npc = EXC_VECTOR;
        else if (eret)
            npc = epc;
        // A branch resolving on the same edge as an issue steers that issue.
        else if (branch_taken)
            npc = branch_target;
        else if (pending_valid)
            npc = pending_target;
        misaligned = (npc[1:0] != 2'b00);
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ack handshake, registered bundle
// to decode. Optional AdEL fetch-fault reporting under IF_ADEL_CHECK_EN.
//
// Handshake: imem_req rises with imem_addr and both stay stable until the
// edge where imem_ack=1; that edge completes the request and imem_rdata is
// sampled on it. A new request may be issued on the same edge.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        except,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out,
    output logic        bad_addr_out,
    output logic        flush_out,
    output logic [1:0]  fsm_state
);

    if_state_t   state, state_n;
    logic        req_n;
    logic [31:0] addr_n, fpc, fpc_n;
    logic        pending_valid, pending_valid_n;
    logic [31:0] pending_target, pending_target_n;
    logic [31:0] hold_inst, hold_inst_n;
    logic        adel_wait, adel_wait_n;
    logic        halted, halted_n;
    logic [31:0] pc_n, inst_n;
    logic        valid_n, bad_q, bad_n;
    logic        kill;
    logic [31:0] npc;
    logic        npc_mis;
    logic        do_issue, issue_fpc, use_npc, issue_mis;
    logic [31:0] issue_addr;

    assign kill      = except | eret;
    assign fsm_state = state;

    if_npc_sel #(.EXC_VECTOR(EXC_VECTOR)) u_npc_sel (
        .except         (except),
        .eret           (eret),
        .epc            (epc),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pending_valid  (pending_valid),
        .pending_target (pending_target),
        .fpc            (fpc),
        .npc            (npc),
        .misaligned     (npc_mis)
    );

    always_comb begin
        state_n          = state;
        req_n            = imem_req;
        addr_n           = imem_addr;
        fpc_n            = fpc;
        pending_valid_n  = pending_valid;
        pending_target_n = pending_target;
        hold_inst_n      = hold_inst;
        adel_wait_n      = adel_wait;
        halted_n         = halted;
        pc_n             = pc_out;
        inst_n           = inst_out;
        valid_n          = valid_out;
        bad_n            = bad_q;
        do_issue         = 1'b0;
        issue_fpc        = 1'b0;
        use_npc          = 1'b0;

        if (!stall) begin
            valid_n = 1'b0;
            inst_n  = NOP_INST;
            bad_n   = 1'b0;
        end
        if (branch_taken) begin
            pending_valid_n  = 1'b1;
            pending_target_n = branch_target;
        end

        if (kill) begin
            pending_valid_n = 1'b0;
            valid_n         = 1'b0;
            inst_n          = NOP_INST;
            bad_n           = 1'b0;
            adel_wait_n     = 1'b0;
            halted_n        = 1'b0;
            // An unacked request must drain through CANCEL; otherwise redirect now.
            if ((state == CANCEL || (state == FETCH && imem_req)) && !imem_ack) begin
                state_n = CANCEL;
                fpc_n   = npc;
            end else begin
                state_n  = FETCH;
                do_issue = 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req) begin
                        if (imem_ack && !stall) begin
                            pc_n     = fpc;
                            inst_n   = imem_rdata;
                            valid_n  = 1'b1;
                            do_issue = 1'b1;
                            use_npc  = 1'b1;
                        end else if (imem_ack) begin
                            hold_inst_n = imem_rdata;
                            req_n       = 1'b0;
                            state_n     = HOLD;
                        end
                    end else if (adel_wait) begin
                        if (!stall) begin
                            pc_n        = fpc;
                            inst_n      = NOP_INST;
                            valid_n     = 1'b1;
                            bad_n       = 1'b1;
                            adel_wait_n = 1'b0;
                            halted_n    = 1'b1;
                        end
                    end else if (!halted) begin
                        do_issue  = 1'b1;
                        issue_fpc = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_n     = fpc;
                        inst_n   = hold_inst;
                        valid_n  = 1'b1;
                        state_n  = FETCH;
                        do_issue = 1'b1;
                        use_npc  = 1'b1;
                    end
                end
                CANCEL: begin
                    if (imem_ack) begin
                        state_n   = FETCH;
                        do_issue  = 1'b1;
                        issue_fpc = 1'b1;
                    end
                end
                default: state_n = FETCH;
            endcase
        end

        if (use_npc)
            pending_valid_n = 1'b0;

        issue_addr = issue_fpc ? fpc : npc;
        issue_mis  = issue_fpc ? (fpc[1:0] != 2'b00) : npc_mis;
        if (do_issue) begin
`ifdef IF_ADEL_CHECK_EN
            fpc_n = issue_addr;
            if (issue_mis) begin
                req_n       = 1'b0;
                adel_wait_n = 1'b1;
            end else begin
                req_n  = 1'b1;
                addr_n = issue_addr;
            end
`else
            fpc_n  = issue_mis ? {issue_addr[31:2], 2'b00} : issue_addr;
            req_n  = 1'b1;
            addr_n = fpc_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= FETCH;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            fpc            <= RESET_PC;
            pending_valid  <= 1'b0;
            pending_target <= 32'h0;
            hold_inst      <= NOP_INST;
            adel_wait      <= 1'b0;
            halted         <= 1'b0;
            pc_out         <= 32'h0;
            inst_out       <= NOP_INST;
            valid_out      <= 1'b0;
            bad_q          <= 1'b0;
            flush_out      <= 1'b0;
        end else begin
            state          <= state_n;
            imem_req       <= req_n;
            imem_addr      <= addr_n;
            fpc            <= fpc_n;
            pending_valid  <= pending_valid_n;
            pending_target <= pending_target_n;
            hold_inst      <= hold_inst_n;
            adel_wait      <= adel_wait_n;
            halted         <= halted_n;
            pc_out         <= pc_n;
            inst_out       <= inst_n;
            valid_out      <= valid_n;
            bad_q          <= bad_n;
            flush_out      <= kill;
        end
    end

    assign bad_addr_out = bad_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, stall/hold, delay slot,
// exception cancel, ERET redirect and kill/branch collision.
module tb_if_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        except;
    logic        eret;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic        bad_addr_out;
    logic        flush_out;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .except        (except),
        .eret          (eret),
        .epc           (epc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc_out        (pc_out),
        .inst_out      (inst_out),
        .valid_out     (valid_out),
        .bad_addr_out  (bad_addr_out),
        .flush_out     (flush_out),
        .fsm_state     (fsm_state)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        except = 1'b0; eret = 1'b0; epc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
    endtask

    // Leaves the DUT one cycle after release: request for BFC00000 outstanding.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic ack_word(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'hBFC00000) begin bad++; $display("FAIL reset_addr: got %h want bfc00000", imem_addr); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", inst_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        total++; if (bad_addr_out !== 1'b0) begin bad++; $display("FAIL reset_bad: got %b want 0", bad_addr_out); end
        total++; if (flush_out !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush_out); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        rst = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00000) begin bad++; $display("FAIL first_req: got %b/%h want 1/bfc00000", imem_req, imem_addr); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL first_valid: got %b want 0", valid_out); end
    endtask

    task automatic test_stream();
        logic [31:0] words[3];
        logic [31:0] pc_exp;
        words[0] = 32'h3C011234; words[1] = 32'h24020005; words[2] = 32'h00221820;
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_exp = 32'hBFC00000 + 32'(4 * i);
            imem_rdata = words[i];
            step();
            total++; if (valid_out !== 1'b1 || pc_out !== pc_exp || inst_out !== words[i]) begin bad++; $display("FAIL stream_out%0d: got %b/%h/%h want 1/%h/%h", i, valid_out, pc_out, inst_out, pc_exp, words[i]); end
            total++; if (imem_req !== 1'b1 || imem_addr !== pc_exp + 32'd4) begin bad++; $display("FAIL stream_addr%0d: got %b/%h want 1/%h", i, imem_req, imem_addr, pc_exp + 32'd4); end
        end
        imem_ack = 1'b0;
        step();
        total++; if (valid_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'hBFC00008) begin bad++; $display("FAIL stream_idle: got %b/%h/%h want 0/0/bfc00008", valid_out, inst_out, pc_out); end
    endtask

    task automatic test_stall();
        do_reset();
        ack_word(32'h11111111);
        stall = 1'b1;
        ack_word(32'h24020001);
        total++; if (fsm_state !== 2'd1 || imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold: got state %0d req %b want 1/0", fsm_state, imem_req); end
        total++; if (valid_out !== 1'b1 || pc_out !== 32'hBFC00000 || inst_out !== 32'h11111111) begin bad++; $display("FAIL stall_frozen: got %b/%h/%h want 1/bfc00000/11111111", valid_out, pc_out, inst_out); end
        step();
        total++; if (fsm_state !== 2'd1 || inst_out !== 32'h11111111) begin bad++; $display("FAIL stall_frozen2: got %0d/%h want 1/11111111", fsm_state, inst_out); end
        stall = 1'b0;
        step();
        total++; if (valid_out !== 1'b1 || pc_out !== 32'hBFC00004 || inst_out !== 32'h24020001) begin bad++; $display("FAIL stall_release: got %b/%h/%h want 1/bfc00004/24020001", valid_out, pc_out, inst_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00008 || fsm_state !== 2'd0) begin bad++; $display("FAIL stall_next: got %b/%h/%0d want 1/bfc00008/0", imem_req, imem_addr, fsm_state); end
    endtask

    task automatic test_branch();
        do_reset();
        ack_word(32'h10000003);
        branch_taken = 1'b1; branch_target = 32'h80000100;
        step();
        branch_taken = 1'b0; branch_target = 32'h0;
        total++; if (imem_addr !== 32'hBFC00004 || imem_req !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL branch_wait: got %h/%b/%b want bfc00004/1/0", imem_addr, imem_req, valid_out); end
        total++; if (dut.pending_valid !== 1'b1) begin bad++; $display("FAIL branch_pending: got %b want 1", dut.pending_valid); end
        ack_word(32'hAAAA0001);
        total++; if (valid_out !== 1'b1 || pc_out !== 32'hBFC00004 || inst_out !== 32'hAAAA0001) begin bad++; $display("FAIL branch_slot: got %b/%h/%h want 1/bfc00004/aaaa0001", valid_out, pc_out, inst_out); end
        total++; if (imem_addr !== 32'h80000100 || dut.pending_valid !== 1'b0) begin bad++; $display("FAIL branch_target: got %h/%b want 80000100/0", imem_addr, dut.pending_valid); end
        ack_word(32'hAAAA0002);
        total++; if (pc_out !== 32'h80000100 || imem_addr !== 32'h80000104) begin bad++; $display("FAIL branch_after: got %h/%h want 80000100/80000104", pc_out, imem_addr); end
    endtask

    task automatic test_branch_same_edge();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'h80000200;
        ack_word(32'h0BBB0000);
        branch_taken = 1'b0;
        total++; if (pc_out !== 32'hBFC00000 || inst_out !== 32'h0BBB0000 || imem_addr !== 32'h80000200) begin bad++; $display("FAIL branch_same: got %h/%h/%h want bfc00000/0bbb0000/80000200", pc_out, inst_out, imem_addr); end
    endtask

    task automatic test_except();
        do_reset();
        ack_word(32'h00000001);
        ack_word(32'h00000002);
        total++; if (imem_addr !== 32'hBFC00008) begin bad++; $display("FAIL exc_pre: got %h want bfc00008", imem_addr); end
        except = 1'b1;
        step();
        except = 1'b0;
        total++; if (valid_out !== 1'b0 || flush_out !== 1'b1 || fsm_state !== 2'd2) begin bad++; $display("FAIL exc_kill: got %b/%b/%0d want 0/1/2", valid_out, flush_out, fsm_state); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00008) begin bad++; $display("FAIL exc_stable: got %b/%h want 1/bfc00008", imem_req, imem_addr); end
        step();
        total++; if (flush_out !== 1'b0) begin bad++; $display("FAIL exc_flush_pulse: got %b want 0", flush_out); end
        ack_word(32'hDEADBEEF);
        total++; if (valid_out !== 1'b0 || inst_out !== 32'h0) begin bad++; $display("FAIL exc_discard: got %b/%h want 0/0", valid_out, inst_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hBFC00380 || fsm_state !== 2'd0) begin bad++; $display("FAIL exc_vector: got %b/%h/%0d want 1/bfc00380/0", imem_req, imem_addr, fsm_state); end
        ack_word(32'h40806000);
        total++; if (valid_out !== 1'b1 || pc_out !== 32'hBFC00380 || inst_out !== 32'h40806000) begin bad++; $display("FAIL exc_handler: got %b/%h/%h want 1/bfc00380/40806000", valid_out, pc_out, inst_out); end
    endtask

    task automatic test_kill_collisions();
        do_reset();
        except = 1'b1; branch_taken = 1'b1; branch_target = 32'h80000100;
        step();
        except = 1'b0; branch_taken = 1'b0;
        total++; if (dut.pending_valid !== 1'b0 || fsm_state !== 2'd2) begin bad++; $display("FAIL kill_branch_pend: got %b/%0d want 0/2", dut.pending_valid, fsm_state); end
        ack_word(32'h12345678);
        total++; if (imem_addr !== 32'hBFC00380 || dut.pending_valid !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL kill_branch_next: got %h/%b/%b want bfc00380/0/0", imem_addr, dut.pending_valid, valid_out); end
        do_reset();
        except = 1'b1;
        ack_word(32'h87654321);
        except = 1'b0;
        total++; if (valid_out !== 1'b0 || fsm_state !== 2'd0 || imem_addr !== 32'hBFC00380 || imem_req !== 1'b1) begin bad++; $display("FAIL kill_ack_same: got %b/%0d/%h/%b want 0/0/bfc00380/1", valid_out, fsm_state, imem_addr, imem_req); end
        stall = 1'b1;
        ack_word(32'h55555555);
        except = 1'b1;
        step();
        except = 1'b0; stall = 1'b0;
        total++; if (fsm_state !== 2'd0 || imem_addr !== 32'hBFC00380 || valid_out !== 1'b0 || flush_out !== 1'b1) begin bad++; $display("FAIL kill_hold: got %0d/%h/%b/%b want 0/bfc00380/0/1", fsm_state, imem_addr, valid_out, flush_out); end
    endtask

    task automatic test_eret();
        do_reset();
        eret = 1'b1; epc = 32'h80000002;
        step();
        eret = 1'b0; epc = 32'h0;
        total++; if (flush_out !== 1'b1 || fsm_state !== 2'd2) begin bad++; $display("FAIL eret_kill: got %b/%0d want 1/2", flush_out, fsm_state); end
        ack_word(32'hCAFE0000);
`ifdef IF_ADEL_CHECK_EN
        total++; if (imem_req !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL eret_noreq: got %b/%b want 0/0", imem_req, valid_out); end
        step();
        total++; if (valid_out !== 1'b1 || inst_out !== 32'h0 || pc_out !== 32'h80000002 || bad_addr_out !== 1'b1) begin bad++; $display("FAIL eret_adel: got %b/%h/%h/%b want 1/0/80000002/1", valid_out, inst_out, pc_out, bad_addr_out); end
        step();
        total++; if (imem_req !== 1'b0 || valid_out !== 1'b0 || bad_addr_out !== 1'b0) begin bad++; $display("FAIL eret_idle: got %b/%b/%b want 0/0/0", imem_req, valid_out, bad_addr_out); end
`else
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80000000) begin bad++; $display("FAIL eret_aligned: got %b/%h want 1/80000000", imem_req, imem_addr); end
        ack_word(32'h0000000C);
        total++; if (valid_out !== 1'b1 || pc_out !== 32'h80000000 || bad_addr_out !== 1'b0) begin bad++; $display("FAIL eret_deliver: got %b/%h/%b want 1/80000000/0", valid_out, pc_out, bad_addr_out); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_same_edge();
        test_except();
        test_kill_collisions();
        test_eret();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and delivers a registered `{pc, inst, valid}` bundle to decode. It honours pipeline stall, taken branches/jumps with one delay slot, and exception/ERET redirection, which kill in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC00000: first fetch address after reset.
- `EXC_VECTOR`, 32'hBFC00380: exception entry address.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `stall`  in  1  decode not accepting (decode `write` deasserted).
- `branch_taken`  in  1  one-cycle pulse: branch/jump in decode resolved taken.
- `branch_target`  in  32  target, valid with `branch_taken`.
- `except`  in  1  one-cycle pulse from writeback: exception taken.
- `eret`  in  1  one-cycle pulse: ERET committed.
- `epc`  in  32  return address, valid with `eret`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address; stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1  `imem_rdata` valid; completes the request.
- `imem_rdata`  in  32  instruction word.
- `pc_out`  out  32  PC of delivered instruction.
- `inst_out`  out  32  delivered instruction; 0 (NOP) when invalid.
- `valid_out`  out  1  `inst_out` is a real instruction.
- `bad_addr_out`  out  1  delivered slot is an AdEL fetch fault.
- `flush_out`  out  1  registered kill indication to decode (`flush`).

## Operation
- States: `FETCH` (request outstanding), `HOLD` (word captured, decode stalled), `CANCEL` (killed request outstanding, result to discard).
- Redirect priority: `except` > `eret` > `branch_taken` > sequential (`fpc+4`, 32-bit wrap).
- Next fetch address `npc`: `EXC_VECTOR` on `except`; `epc` on `eret`; otherwise `pending_target` if `pending_valid`, else `fpc+4`.
- `branch_taken`: sets `pending_valid`/`pending_target`. The request already outstanding or held is the delay slot and is delivered. The target is used for the next issued request, then `pending_valid` clears. A second `branch_taken` before use overwrites.
- Kill (`except`|`eret`): clears `pending_valid`. `FETCH`→`CANCEL`; `HOLD`→`FETCH` (held word dropped). `fpc`←redirect. `flush_out`=1 next cycle. Kill overrides `stall`.
- `FETCH` + ack, `stall`=0: deliver word, issue `npc` same edge (req stays high).
- `FETCH` + ack, `stall`=1: capture into hold buffer, drop req, go to `HOLD`.
- `HOLD`, `stall`=0: deliver held word, issue `npc`, go to `FETCH`.
- `CANCEL` + ack: discard rdata, issue `fpc`, go to `FETCH`.
- `stall`=0 and nothing delivered: `valid_out`=0, `inst_out`=0, `pc_out` holds.
- `stall`=1: `pc_out`, `inst_out`, `valid_out`, `bad_addr_out` hold, except on kill, which sets `valid_out`=0.

## Timing
- Reset (`rst`=0 at edge): `imem_req`=0, `imem_addr`=`RESET_PC`, `pc_out`=0, `inst_out`=0, `valid_out`=0, `bad_addr_out`=0, `flush_out`=0, `fpc`=`RESET_PC`, `pending_valid`=0, state `FETCH` with no request.
- First edge with `rst`=1: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Reset mid-operation abandons any outstanding request. Imem shares `rst`, so no stale ack is returned.
- Ack earliest one cycle after req rises; unbounded wait permitted.
- Ack at edge N: output registers valid from N (visible N+1). Throughput is one instruction per cycle with zero-wait memory.
- Kill and ack on the same edge: the ack belongs to the killed request and is discarded. Next request is the redirect address, with no `CANCEL` needed.
- `branch_taken` and ack on the same edge: the acked word is the delay slot; the request issued on that edge uses the target.

## Configuration
- `IF_ADEL_CHECK_EN` defined: when `npc[1:0]`≠0, no request is issued. Next deliverable slot: `valid_out`=1, `inst_out`=0, `pc_out`=bad address, `bad_addr_out`=1. Fetch then idles until a kill.
- `IF_ADEL_CHECK_EN` undefined: `imem_addr` forced to `{npc[31:2],2'b00}` and `bad_addr_out` tied 0.

## Structure
- Shared `mips_pkg`: `RESET_PC`/`EXC_VECTOR` defaults, `NOP_INST`=32'h0, `if_state_t` enum.
- Sub-module `if_npc_sel`: combinational redirect-priority mux producing `npc` and the misalignment flag.

## Test plan
- Reset, zero-wait ack: `imem_addr` sequence BFC00000, BFC00004, BFC00008. `valid_out`=1 from the second cycle after release; `pc_out` follows, one per cycle.
- `stall`=1 across an ack for BFC00004 (rdata 0x24020001): state `HOLD`, req=0, outputs frozen. Release `stall`: `inst_out`=0x24020001, `pc_out`=BFC00004, next req BFC00008.
- `branch_taken` with target 0x80000100 while BFC00004 outstanding: BFC00004 delivered (delay slot), next `imem_addr`=80000100.
- `except` while BFC00008 outstanding with 3-cycle ack latency: returned word discarded, `valid_out`=0, `flush_out`=1. Next req BFC00380.
- `eret`, `epc`=0x80000002, macro defined: no req. Slot delivered with `valid_out`=1, `inst_out`=0, `pc_out`=80000002, `bad_addr_out`=1.
- `except` and `branch_taken` on the same edge: next req is BFC00380 and `pending_valid`=0.
